mem_arbiter: RTL and testbench

- Shares one data-memory port between CORE_COUNT cores.
- Each core drives its enable_M/addr_M/wr_data_M and stalls its pipeline until it sees its own ready_M.
- The arbiter grants one request at a time in round-robin order, runs the memory handshake and returns read data with a one-cycle ready pulse to the granted core.
- A timeout counter guards against a memory that never answers.

---
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between CORE_COUNT cores.
// One transaction at a time: IDLE grants and latches, BUSY waits on memory, DONE pulses ready.
module mem_arbiter #(
    parameter int CORE_COUNT = 4,
    parameter int REG_SIZE   = 8,
    parameter int ADDR_SIZE  = 10,
    parameter int TIMEOUT    = 255
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2*CORE_COUNT-1:0]          core_enable,
    input  logic [ADDR_SIZE*CORE_COUNT-1:0]  core_addr,
    input  logic [REG_SIZE*CORE_COUNT-1:0]   core_wr_data,
    output logic [CORE_COUNT-1:0]            core_ready,
    output logic [REG_SIZE-1:0]              core_rd_data,
    output logic [1:0]                       mem_enable,
    output logic [ADDR_SIZE-1:0]             mem_addr,
    output logic [REG_SIZE-1:0]              mem_wr_data,
    input  logic [REG_SIZE-1:0]              mem_rd_data,
    input  logic                             mem_ready,
    output logic                             busy,
    output logic                             timeout_err
);

    localparam int IDW = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;
    localparam int CW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDW-1:0]       rr_q, rr_d;
    logic [IDW-1:0]       grant_q, grant_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [1:0]           men_q, men_d;
    logic [ADDR_SIZE-1:0] maddr_q, maddr_d;
    logic [REG_SIZE-1:0]  mwd_q, mwd_d;
    logic [REG_SIZE-1:0]  rd_q, rd_d;
    logic                 terr_q, terr_d;

    logic [1:0]           req_op   [CORE_COUNT];
    logic [ADDR_SIZE-1:0] req_addr [CORE_COUNT];
    logic [REG_SIZE-1:0]  req_wd   [CORE_COUNT];
    logic [CORE_COUNT-1:0] req_valid;

    logic                 pick_found;
    logic [IDW-1:0]       pick_idx;

    // 2'b11 is treated as no request so it can never reach the memory port.
    always_comb begin
        req_valid = '0;
        for (int unsigned i = 0; i < CORE_COUNT; i++) begin
            req_op[i]    = core_enable[2*i +: 2];
            req_addr[i]  = core_addr[ADDR_SIZE*i +: ADDR_SIZE];
            req_wd[i]    = core_wr_data[REG_SIZE*i +: REG_SIZE];
            req_valid[i] = (req_op[i] == 2'b01) || (req_op[i] == 2'b10);
        end
    end

    always_comb begin
        logic [IDW-1:0] cand;
        cand       = '0;
        pick_found = 1'b0;
        pick_idx   = rr_q;
        for (int unsigned off = 0; off < CORE_COUNT; off++) begin
            cand = rr_q + IDW'(off);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        men_d   = men_q;
        maddr_d = maddr_q;
        mwd_d   = mwd_q;
        rd_d    = rd_q;
        terr_d  = terr_q;
        case (state_q)
            IDLE: begin
                men_d = 2'b00;
                if (pick_found) begin
                    grant_d = pick_idx;
                    men_d   = req_op[pick_idx];
                    maddr_d = req_addr[pick_idx];
                    mwd_d   = req_wd[pick_idx];
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    rd_d    = (men_q == 2'b01) ? mem_rd_data : '0;
                    men_d   = 2'b00;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q + CW'(1) == CW'(TIMEOUT)) begin
                        terr_d  = 1'b1;
                        rd_d    = '0;
                        men_d   = 2'b00;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                rr_d    = grant_q + IDW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            rr_q    <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
            men_q   <= '0;
            maddr_q <= '0;
            mwd_q   <= '0;
            rd_q    <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            men_q   <= men_d;
            maddr_q <= maddr_d;
            mwd_q   <= mwd_d;
            rd_q    <= rd_d;
            terr_q  <= terr_d;
        end
    end

    always_comb begin
        core_ready = '0;
        if (state_q == DONE) core_ready[grant_q] = 1'b1;
    end

    assign core_rd_data = rd_q;
    assign mem_enable   = men_q;
    assign mem_addr     = maddr_q;
    assign mem_wr_data  = mwd_q;
    assign busy         = (state_q != IDLE);
    assign timeout_err  = terr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random requests
// checked against a transaction-level round-robin model.
module tb_mem_arbiter;

    localparam int N  = 4;
    localparam int RS = 8;
    localparam int AS = 10;
    localparam int TO = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [2*N-1:0]    core_enable;
    logic [AS*N-1:0]   core_addr;
    logic [RS*N-1:0]   core_wr_data;
    logic [N-1:0]      core_ready;
    logic [RS-1:0]     core_rd_data;
    logic [1:0]        mem_enable;
    logic [AS-1:0]     mem_addr;
    logic [RS-1:0]     mem_wr_data;
    logic [RS-1:0]     mem_rd_data;
    logic              mem_ready;
    logic              busy;
    logic              timeout_err;

    mem_arbiter #(.CORE_COUNT(N), .REG_SIZE(RS), .ADDR_SIZE(AS), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .core_enable(core_enable), .core_addr(core_addr),
        .core_wr_data(core_wr_data), .core_ready(core_ready), .core_rd_data(core_rd_data),
        .mem_enable(mem_enable), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data), .mem_ready(mem_ready), .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int m_rr = 0;
    bit m_terr = 1'b0;

    // Reference: first valid requester at or after rr, wrapping.
    function automatic int pick(input int rr, input logic [2*N-1:0] en);
        for (int k = 0; k < N; k++) begin
            int c;
            logic [1:0] e;
            c = (rr + k) % N;
            e = en[2*c +: 2];
            if (e == 2'b01 || e == 2'b10) return c;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; core_enable = '0; mem_ready = 1'b0;
        tick(); tick();
        reset = 1'b1;
        m_rr = 0; m_terr = 1'b0;
    endtask

    task automatic serve(input int lat, input logic [RS-1:0] rdv, input bit drop, output int waited);
        int g;
        logic [1:0] op;
        logic [AS-1:0] ea;
        logic [RS-1:0] ew;
        logic [N-1:0] oh;
        waited = 0;
        g = pick(m_rr, core_enable);
        if (g < 0) return;
        op = core_enable[2*g +: 2];
        ea = core_addr[AS*g +: AS];
        ew = core_wr_data[RS*g +: RS];
        oh = N'(1) << g;
        mem_rd_data = RS'($urandom);
        while (waited < 8 && mem_enable == 2'b00) begin tick(); waited++; end
        tests++; if (mem_enable !== op) begin fails++; $display("FAIL grant_op: mem_enable=%b required %b (core %0d)", mem_enable, op, g); end
        tests++; if (mem_addr !== ea) begin fails++; $display("FAIL grant_addr: mem_addr=%h required %h (core %0d)", mem_addr, ea, g); end
        tests++; if (mem_wr_data !== ew) begin fails++; $display("FAIL grant_wdata: mem_wr_data=%h required %h (core %0d)", mem_wr_data, ew, g); end
        tests++; if (busy !== 1'b1 || core_ready !== '0) begin fails++; $display("FAIL busy_phase: busy=%b core_ready=%b required 1/0000", busy, core_ready); end
        if (drop) core_enable[2*g +: 2] = 2'b00;
        for (int k = 0; k < lat; k++) begin
            tick();
            tests++; if (mem_enable !== op || core_ready !== '0) begin fails++; $display("FAIL hold: mem_enable=%b core_ready=%b required %b/0000", mem_enable, core_ready, op); end
        end
        mem_ready = 1'b1; mem_rd_data = rdv;
        tick();
        mem_ready = 1'b0; mem_rd_data = RS'($urandom);
        tests++; if (core_ready !== oh) begin fails++; $display("FAIL ready_pulse: core_ready=%b required %b", core_ready, oh); end
        tests++; if (core_rd_data !== ((op == 2'b01) ? rdv : '0)) begin fails++; $display("FAIL rd_data: core_rd_data=%h required %h", core_rd_data, (op == 2'b01) ? rdv : '0); end
        tests++; if (mem_enable !== 2'b00 || busy !== 1'b1) begin fails++; $display("FAIL done_phase: mem_enable=%b busy=%b required 00/1", mem_enable, busy); end
        tests++; if (timeout_err !== m_terr) begin fails++; $display("FAIL terr_flag: timeout_err=%b required %b", timeout_err, m_terr); end
        m_rr = (g + 1) % N;
        tick();
        tests++; if (core_ready !== '0 || busy !== 1'b0) begin fails++; $display("FAIL back_idle: core_ready=%b busy=%b required 0000/0", core_ready, busy); end
    endtask

    task automatic test_reset();
        reset = 1'b0; core_enable = 8'b0110_1001; mem_ready = 1'b1;
        core_addr = AS*N'($urandom); core_wr_data = RS*N'($urandom); mem_rd_data = 8'hFF;
        tick(); tick();
        tests++; if (core_ready !== '0) begin fails++; $display("FAIL rst_ready: got %b required 0", core_ready); end
        tests++; if (core_rd_data !== '0) begin fails++; $display("FAIL rst_rd: got %h required 0", core_rd_data); end
        tests++; if (mem_enable !== '0) begin fails++; $display("FAIL rst_men: got %b required 0", mem_enable); end
        tests++; if (mem_addr !== '0) begin fails++; $display("FAIL rst_addr: got %h required 0", mem_addr); end
        tests++; if (mem_wr_data !== '0) begin fails++; $display("FAIL rst_wd: got %h required 0", mem_wr_data); end
        tests++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin fails++; $display("FAIL rst_flags: busy=%b terr=%b required 0/0", busy, timeout_err); end
        reset = 1'b1; core_enable = '0; mem_ready = 1'b0;
        m_rr = 0; m_terr = 1'b0;
        tick();
    endtask

    task automatic test_single_ld();
        int w;
        core_enable = 8'b0001_0000;
        core_addr[AS*2 +: AS] = 10'h0A5;
        serve(1, 8'h3C, 1'b0, w);
        core_enable = '0;
    endtask

    task automatic test_wrap();
        int w;
        core_enable = 8'b1000_1000;
        serve(0, RS'($urandom), 1'b0, w);
        serve(0, RS'($urandom), 1'b0, w);
        core_enable = 8'b1010_1010;
        serve(0, RS'($urandom), 1'b0, w);
        core_enable = '0;
    endtask

    task automatic test_round_robin();
        int w;
        do_reset();
        core_enable = 8'b1010_1010;
        for (int i = 0; i < N; i++) core_wr_data[RS*i +: RS] = RS'(8'h11 * (i + 1));
        for (int i = 0; i < 5; i++) begin
            serve(0, RS'($urandom), 1'b0, w);
            tests++; if (w !== 1) begin fails++; $display("FAIL rr_b2b: grant after %0d cycles required 1", w); end
        end
        core_enable = '0;
    endtask

    task automatic test_timeout();
        int w;
        do_reset();
        core_enable = 8'b0000_0001;
        serve(0, 8'hA5, 1'b0, w);
        w = 0;
        while (w < 8 && mem_enable == 2'b00) begin tick(); w++; end
        tests++; if (mem_enable !== 2'b01) begin fails++; $display("FAIL to_grant: mem_enable=%b required 01", mem_enable); end
        core_enable = '0;
        for (int k = 0; k < TO - 1; k++) begin
            tick();
            tests++; if (core_ready !== '0 || timeout_err !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL to_wait: core_ready=%b terr=%b busy=%b required 0000/0/1", core_ready, timeout_err, busy); end
        end
        tick();
        m_terr = 1'b1; m_rr = 1;
        tests++; if (core_ready !== 4'b0001) begin fails++; $display("FAIL to_ready: core_ready=%b required 0001", core_ready); end
        tests++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL to_err: timeout_err=%b required 1", timeout_err); end
        tests++; if (core_rd_data !== '0 || mem_enable !== 2'b00) begin fails++; $display("FAIL to_data: rd=%h men=%b required 00/00", core_rd_data, mem_enable); end
        tick();
        core_enable = 8'b1000_0000;
        serve(2, RS'($urandom), 1'b0, w);
        core_enable = 8'b0000_0100;
        serve(0, RS'($urandom), 1'b0, w);
        core_enable = '0;
        do_reset();
        tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL to_clear: timeout_err=%b required 0", timeout_err); end
    endtask

    task automatic test_reset_midop();
        int w;
        do_reset();
        core_enable = 8'b0000_0100;
        w = 0;
        while (w < 8 && mem_enable == 2'b00) begin tick(); w++; end
        tests++; if (mem_enable !== 2'b01) begin fails++; $display("FAIL mid_grant: mem_enable=%b required 01", mem_enable); end
        reset = 1'b0; core_enable = '0;
        tick();
        tests++; if (mem_enable !== '0 || busy !== 1'b0 || core_ready !== '0) begin fails++; $display("FAIL mid_rst: men=%b busy=%b ready=%b required 0", mem_enable, busy, core_ready); end
        tests++; if (mem_addr !== '0 || mem_wr_data !== '0 || core_rd_data !== '0) begin fails++; $display("FAIL mid_rst_data: addr=%h wd=%h rd=%h required 0", mem_addr, mem_wr_data, core_rd_data); end
        reset = 1'b1; mem_ready = 1'b1; mem_rd_data = 8'h77;
        m_rr = 0; m_terr = 1'b0;
        tick();
        mem_ready = 1'b0;
        tests++; if (core_ready !== '0) begin fails++; $display("FAIL mid_late1: core_ready=%b required 0", core_ready); end
        tick();
        tests++; if (core_ready !== '0 || busy !== 1'b0) begin fails++; $display("FAIL mid_late2: core_ready=%b busy=%b required 0/0", core_ready, busy); end
        core_enable = 8'b1010_1010;
        serve(0, RS'($urandom), 1'b0, w);
        core_enable = '0;
    endtask

    task automatic test_illegal();
        int w;
        do_reset();
        core_enable = 8'b0010_1100;
        serve(0, RS'($urandom), 1'b0, w);
        serve(1, RS'($urandom), 1'b0, w);
        core_enable = 8'b0000_1100;
        for (int k = 0; k < 6; k++) begin
            tick();
            tests++; if (mem_enable !== '0 || core_ready !== '0) begin fails++; $display("FAIL illegal_idle: men=%b ready=%b required 00/0000", mem_enable, core_ready); end
        end
        core_enable = '0;
    endtask

    task automatic test_random();
        int w;
        for (int it = 0; it < 40; it++) begin
            for (int c = 0; c < N; c++) begin
                core_enable[2*c +: 2] = 2'($urandom_range(0, 3));
                core_addr[AS*c +: AS] = AS'($urandom);
                core_wr_data[RS*c +: RS] = RS'($urandom);
            end
            if (pick(m_rr, core_enable) < 0) begin
                for (int k = 0; k < 3; k++) begin
                    tick();
                    tests++; if (mem_enable !== '0 || busy !== 1'b0) begin fails++; $display("FAIL rand_idle: men=%b busy=%b required 00/0", mem_enable, busy); end
                end
            end else begin
                serve(int'($urandom_range(0, TO - 1)), RS'($urandom), bit'($urandom_range(0, 1)), w);
            end
        end
        core_enable = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; core_enable = '0; core_addr = '0; core_wr_data = '0;
        mem_rd_data = '0; mem_ready = 1'b0;
        test_reset();
        test_single_ld();
        test_wrap();
        test_round_robin();
        test_timeout();
        test_reset_midop();
        test_illegal();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
